// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - control-step sequencer for register-register ALU instruction fetch/execute
module alu_instr_sequencer #(
    parameter int DATA_W      = 32,
    parameter int REG_CNT     = 16,
    parameter int OPC_W       = 5,
    parameter int DIV_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [DATA_W-1:0]  ir,
    input  logic               mem_ack,
    output logic               pc_out,
    output logic               mar_in,
    output logic               inc_pc,
    output logic               pc_in,
    output logic               read,
    output logic               mdr_in,
    output logic               mdr_out,
    output logic               ir_in,
    output logic               y_in,
    output logic               zhi_in,
    output logic               zlo_in,
    output logic               zhi_out,
    output logic               zlo_out,
    output logic               hi_in,
    output logic               lo_in,
    output logic [REG_CNT-1:0] reg_out,
    output logic [REG_CNT-1:0] reg_in,
    output logic [OPC_W-1:0]   alu_op,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [3:0]         step
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int DIV_W  = $clog2(DIV_CYCLES + 1);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        opc_q;
    logic [3:0]        ra_q, rb_q, rc_q;

    // Instruction fields sit in the top 17 bits regardless of DATA_W.
    logic [4:0] ir_opc;
    logic [3:0] ir_ra, ir_rb, ir_rc;
    logic       unused_ir;

    assign ir_opc    = ir[DATA_W-1  -: 5];
    assign ir_ra     = ir[DATA_W-6  -: 4];
    assign ir_rb     = ir[DATA_W-10 -: 4];
    assign ir_rc     = ir[DATA_W-14 -: 4];
    assign unused_ir = ^ir[DATA_W-18:0];

    function automatic logic is_legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
            OP_SHL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: is_legal = 1'b1;
            default:                                is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        is_unary = (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Register fields beyond REG_CNT select nothing rather than wrapping.
    function automatic logic [REG_CNT-1:0] onehot(input logic [3:0] idx);
        logic [REG_CNT-1:0] v;
        for (int i = 0; i < REG_CNT; i++) begin
            v[i] = (i == int'(idx));
        end
        return v;
    endfunction

    logic wait_last, div_last;
    assign wait_last = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign div_last  = (div_cnt  == DIV_W'(DIV_CYCLES - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            div_cnt  <= '0;
            opc_q    <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == S_T1) ? wait_cnt + WAIT_W'(1) : '0;
            div_cnt  <= (state == S_T4 && opc_q == OP_DIV) ? div_cnt + DIV_W'(1) : '0;
            if (state == S_T3) begin
                opc_q <= ir_opc;
                ra_q  <= ir_ra;
                rb_q  <= ir_rb;
                rc_q  <= ir_rc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_out    = 1'b0;
        mar_in    = 1'b0;
        inc_pc    = 1'b0;
        pc_in     = 1'b0;
        read      = 1'b0;
        mdr_in    = 1'b0;
        mdr_out   = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        zhi_in    = 1'b0;
        zlo_in    = 1'b0;
        zhi_out   = 1'b0;
        zlo_out   = 1'b0;
        hi_in     = 1'b0;
        lo_in     = 1'b0;
        reg_out   = '0;
        reg_in    = '0;
        alu_op    = '0;
        busy      = 1'b0;
        done      = 1'b0;
        fault     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_T0;
            end
            S_T0: begin
                busy      = 1'b1;
                pc_out    = 1'b1;
                mar_in    = 1'b1;
                inc_pc    = 1'b1;
                zlo_in    = 1'b1;
                state_nxt = S_T1;
            end
            S_T1: begin
                busy    = 1'b1;
                zlo_out = 1'b1;
                read    = 1'b1;
                mdr_in  = 1'b1;
                pc_in   = (wait_cnt == '0);
                if (mem_ack) begin
                    state_nxt = S_T2;
                end else if (wait_last) begin
                    fault     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_T2: begin
                busy      = 1'b1;
                mdr_out   = 1'b1;
                ir_in     = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                busy = 1'b1;
                if (!is_legal(ir_opc)) begin
                    fault     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    if (!is_unary(ir_opc)) begin
                        reg_out = onehot(ir_rb);
                        y_in    = 1'b1;
                    end
                    state_nxt = S_T4;
                end
            end
            S_T4: begin
                busy    = 1'b1;
                alu_op  = OPC_W'(opc_q);
                reg_out = onehot(is_unary(opc_q) ? rb_q : rc_q);
                // DIV holds operands steady and only captures Z on its final cycle.
                if (opc_q == OP_DIV) begin
                    if (div_last) begin
                        zlo_in    = 1'b1;
                        zhi_in    = 1'b1;
                        state_nxt = S_T5;
                    end
                end else begin
                    zlo_in    = 1'b1;
                    zhi_in    = (opc_q == OP_MUL);
                    state_nxt = S_T5;
                end
            end
            S_T5: begin
                busy    = 1'b1;
                zlo_out = 1'b1;
                if (is_muldiv(opc_q)) begin
                    lo_in     = 1'b1;
                    state_nxt = S_T6;
                end else begin
                    reg_in    = onehot(ra_q);
                    state_nxt = S_DONE;
                end
            end
            S_T6: begin
                busy      = 1'b1;
                zhi_out   = 1'b1;
                hi_in     = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign step = state;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb/tb_alu_instr_sequencer.sv - scoreboard bench for alu_instr_sequencer
module tb_alu_instr_sequencer;

    localparam int DATA_W      = 32;
    localparam int REG_CNT     = 16;
    localparam int OPC_W       = 5;
    localparam int DIV_CYCLES  = 4;
    localparam int MEM_TIMEOUT = 8;

    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;

    logic clk, clr, start, mem_ack;
    logic [DATA_W-1:0] ir;
    logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
    logic zhi_in, zlo_in, zhi_out, zlo_out, hi_in, lo_in;
    logic [REG_CNT-1:0] reg_out, reg_in;
    logic [OPC_W-1:0] alu_op;
    logic busy, done, fault;
    logic [3:0] step;

    alu_instr_sequencer #(
        .DATA_W(DATA_W), .REG_CNT(REG_CNT), .OPC_W(OPC_W),
        .DIV_CYCLES(DIV_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .clr(clr), .start(start), .ir(ir), .mem_ack(mem_ack),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
        .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
        .y_in(y_in), .zhi_in(zhi_in), .zlo_in(zlo_in), .zhi_out(zhi_out),
        .zlo_out(zlo_out), .hi_in(hi_in), .lo_in(lo_in), .reg_out(reg_out),
        .reg_in(reg_in), .alu_op(alu_op), .busy(busy), .done(done),
        .fault(fault), .step(step)
    );

    typedef struct packed {
        logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
        logic zhi_in, zlo_in, zhi_out, zlo_out, hi_in, lo_in;
        logic [15:0] reg_out;
        logic [15:0] reg_in;
        logic [4:0]  alu_op;
        logic busy, done, fault;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        return {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in,
                zhi_in, zlo_in, zhi_out, zlo_out, hi_in, lo_in,
                reg_out, reg_in, alu_op, busy, done, fault};
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] i);
        return 16'd1 << i;
    endfunction

    function automatic bit legal_op(input logic [4:0] op);
        return op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                          5'd15, 5'd16, 5'd17, 5'd18};
    endfunction

    // Reference: expected outputs cycle by cycle from the start cycle onward.
    task automatic build_trace(input logic [31:0] instr, input int d,
                               output int len, output int t1len);
        obs_t o;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit unary, muldiv, tmo;
        int n4;
        op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
        unary  = (op == OP_NEG) || (op == OP_NOT);
        muldiv = (op == OP_MUL) || (op == OP_DIV);
        tmo    = (d >= MEM_TIMEOUT);
        t1len  = tmo ? MEM_TIMEOUT : d + 1;
        len    = 0;
        o = '0; exp_q.push_back(o); len++;
        o = '0; o.busy = 1; o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.zlo_in = 1;
        exp_q.push_back(o); len++;
        for (int i = 0; i < t1len; i++) begin
            o = '0; o.busy = 1; o.zlo_out = 1; o.read = 1; o.mdr_in = 1;
            o.pc_in = (i == 0);
            o.fault = tmo && (i == t1len - 1);
            exp_q.push_back(o); len++;
        end
        if (tmo) return;
        o = '0; o.busy = 1; o.mdr_out = 1; o.ir_in = 1; exp_q.push_back(o); len++;
        o = '0; o.busy = 1;
        if (!legal_op(op)) begin
            o.fault = 1; exp_q.push_back(o); len++;
            return;
        end
        if (!unary) begin o.reg_out = oh(rb); o.y_in = 1; end
        exp_q.push_back(o); len++;
        n4 = (op == OP_DIV) ? DIV_CYCLES : 1;
        for (int i = 0; i < n4; i++) begin
            o = '0; o.busy = 1; o.alu_op = op;
            o.reg_out = unary ? oh(rb) : oh(rc);
            if (i == n4 - 1) begin o.zlo_in = 1; o.zhi_in = muldiv; end
            exp_q.push_back(o); len++;
        end
        o = '0; o.busy = 1; o.zlo_out = 1;
        if (muldiv) o.lo_in = 1; else o.reg_in = oh(ra);
        exp_q.push_back(o); len++;
        if (muldiv) begin
            o = '0; o.busy = 1; o.zhi_out = 1; o.hi_in = 1; exp_q.push_back(o); len++;
        end
        o = '0; o.done = 1; exp_q.push_back(o); len++;
    endtask

    task automatic check_reset(input string name);
        obs_t o;
        o = sample();
        checks++;
        if (o != '0 || step != 4'd0) begin
            errors++;
            $display("FAIL %s: got outputs=%h step=%0d, required all zero", name, o, step);
        end
    endtask

    // Called at posedge+1 with the DUT idle; drives one instruction cycle by cycle.
    task automatic run_instr(input logic [31:0] instr, input int d, input bit noise,
                             input int abort_at);
        int len, t1len;
        build_trace(instr, d, len, t1len);
        for (int c = 0; c < len; c++) begin
            if (c == abort_at) begin
                mon_en = 0;
                exp_q.delete();
                #1 clr = 1'b0;
                #1 check_reset("reset_abort");
                start = 1'b1;
                repeat (2) @(posedge clk);
                #1 check_reset("reset_hold");
                start = 1'b0; mem_ack = 1'b0; clr = 1'b1;
                @(posedge clk); #1;
                mon_en = 1;
                return;
            end
            start = (c == 0) ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            if (c >= 2 && c < 2 + t1len) mem_ack = (c == 2 + d);
            else mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            ir = (c <= 3 + t1len) ? instr : $urandom;
            @(posedge clk); #1;
        end
        start = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            obs_t o, e;
            o = sample();
            checks++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL cycle t=%0t: got=%h required=%h", $time, o, e);
                end
            end else if (o != '0) begin
                errors++;
                $display("FAIL idle t=%0t: got=%h required=0", $time, o);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] instr;
        logic [4:0]  ops [13];
        int k;
        ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                5'd15, 5'd16, 5'd17, 5'd18};
        clr = 1'b0; start = 1'b0; mem_ack = 1'b0; ir = '0;
        repeat (2) @(posedge clk);
        #1 check_reset("reset_initial");
        start = 1'b1;
        @(posedge clk); #1 check_reset("reset_start_ignored");
        start = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        mon_en = 1;

        run_instr(32'h28918000, 0,  0, -1);
        run_instr(32'h28918000, 3,  0, -1);
        run_instr(32'h28918000, 20, 0, -1);
        run_instr(32'h80918000, 0,  0, -1);
        run_instr(32'h91100000, 1,  0, -1);
        run_instr(32'hF8000000, 0,  0, -1);
        run_instr(32'h79A5C000, 2,  0, -1);
        run_instr(32'h18918000, 0,  0, 5);
        run_instr(32'h18918000, 0,  0, -1);
        run_instr(32'h28918000, MEM_TIMEOUT - 1, 1, -1);

        for (int n = 0; n < 80; n++) begin
            instr = $urandom;
            k = $urandom_range(0, 15);
            if (k < 13) instr[31:27] = ops[k];
            run_instr(instr, $urandom_range(0, 10), 1'($urandom_range(0, 1)), -1);
        end

        mon_en = 0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
